// File: rtl/bidim_mux_sequencer.sv
// Sweeps the bidim_mux select over an index range (with wrap-around) and turns the selected
// words into a registered valid/ready stream tagged with their index.
module bidim_mux_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 19,
    localparam int unsigned SEL_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [SEL_WIDTH-1:0] first_i,
    input  logic [SEL_WIDTH-1:0] last_i,
    output logic [SEL_WIDTH-1:0] m_ctrl,
    input  logic [WIDTH-1:0]     m_out,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_idx,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_WIDTH-1:0] r_m_ctrl;
    logic [SEL_WIDTH-1:0] w_m_ctrl_nxt;
    logic [SEL_WIDTH-1:0] r_last_idx;
    logic [SEL_WIDTH-1:0] w_last_idx_nxt;
    logic [WIDTH-1:0]     r_out_data;
    logic [WIDTH-1:0]     w_out_data_nxt;
    logic [SEL_WIDTH-1:0] r_out_idx;
    logic [SEL_WIDTH-1:0] w_out_idx_nxt;
    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic                 r_out_last;
    logic                 w_out_last_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    logic                 w_handshake;
    logic                 w_capture;
    logic                 w_range_ok;
    logic                 w_at_last;
    logic [SEL_WIDTH-1:0] w_ctrl_inc;

    assign w_handshake = r_out_valid && out_ready;
    // Output slot is free when empty or being drained this cycle.
    assign w_capture   = (r_state == S_SCAN) && (!r_out_valid || out_ready);
    assign w_range_ok  = (32'(first_i) < DEPTH) && (32'(last_i) < DEPTH);
    assign w_at_last   = (r_m_ctrl == r_last_idx);
    assign w_ctrl_inc  = (r_m_ctrl == SEL_WIDTH'(DEPTH - 1)) ? '0 : r_m_ctrl + SEL_WIDTH'(1);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_m_ctrl_nxt    = r_m_ctrl;
        w_last_idx_nxt  = r_last_idx;
        w_out_data_nxt  = r_out_data;
        w_out_idx_nxt   = r_out_idx;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_range_ok) begin
                        w_m_ctrl_nxt   = first_i;
                        w_last_idx_nxt = last_i;
                        w_state_nxt    = S_SCAN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (w_capture) begin
                    w_out_data_nxt  = m_out;
                    w_out_idx_nxt   = r_m_ctrl;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = w_at_last;
                    if (w_at_last) begin
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_m_ctrl_nxt = w_ctrl_inc;
                    end
                end
            end
            S_FLUSH: begin
                if (w_handshake) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_m_ctrl    <= '0;
            r_last_idx  <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_m_ctrl    <= w_m_ctrl_nxt;
            r_last_idx  <= w_last_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign m_ctrl    = r_m_ctrl;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
